// File: rtl/fsm_counter_core_if.sv
// Run/done handshake bundle between a control FSM (master) and the counter worker core (slave).
interface fsm_counter_core_if #(
   parameter int unsigned CNT_WIDTH = 7
);
   logic                 i_run;
   logic [CNT_WIDTH-1:0] i_num_cnt;
   logic                 o_idle;
   logic                 o_running;
   logic                 o_done;
   logic [CNT_WIDTH-1:0] o_cnt;

   modport master (
      output i_run, i_num_cnt,
      input  o_idle, o_running, o_done, o_cnt
   );

   modport slave (
      input  i_run, i_num_cnt,
      output o_idle, o_running, o_done, o_cnt
   );
endinterface

// File: rtl/fsm_counter_core.sv
// Worker core: accepts a run request with a cycle count, runs that many cycles, pulses done.
// Outputs are registered alongside the IDLE/RUN/DONE state so they are glitch-free Moore outputs.
module fsm_counter_core #(
   parameter int unsigned CNT_WIDTH = 7
) (
   input logic                clk,
   input logic                reset_n,
   fsm_counter_core_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] num_cnt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 idle;
   logic                 running;
   logic                 done;

   // Counter doubles as o_cnt: cleared outside RUN, so it reads 0 whenever not running.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         num_cnt <= '0;
         cnt     <= '0;
         idle    <= 1'b1;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_run) begin
                  num_cnt <= bus.i_num_cnt;
                  cnt     <= '0;
                  idle    <= 1'b0;
                  // A zero-length request skips RUN entirely.
                  if (bus.i_num_cnt != '0) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end else begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (cnt == num_cnt - CNT_WIDTH'(1)) begin
                  state   <= S_DONE;
                  cnt     <= '0;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               idle  <= 1'b1;
            end
            default: begin
               state   <= S_IDLE;
               cnt     <= '0;
               idle    <= 1'b1;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_idle    = idle;
   assign bus.o_running = running;
   assign bus.o_done    = done;
   assign bus.o_cnt     = cnt;
endmodule

// File: tb/tb_fsm_counter_core.sv
// Directed bench for fsm_counter_core: default width instance plus a 4-bit instance for max N.
module tb_fsm_counter_core;
   logic clk;
   logic reset_n;
   int   n_pass;
   int   n_total;

   fsm_counter_core_if #(.CNT_WIDTH(7)) bus7 ();
   fsm_counter_core_if #(.CNT_WIDTH(4)) bus4 ();

   fsm_counter_core #(.CNT_WIDTH(7)) dut7 (.clk(clk), .reset_n(reset_n), .bus(bus7));
   fsm_counter_core #(.CNT_WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset_n = 1'b0;
      bus7.i_run = 1'b0;
      bus7.i_num_cnt = 7'd0;
      bus4.i_run = 1'b0;
      bus4.i_num_cnt = 4'd0;
      @(negedge clk);
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL reset_flags: got %b expected 100", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
      n_total++;
      if (bus7.o_cnt !== 7'd0) $display("FAIL reset_cnt: got %0d expected 0", bus7.o_cnt);
      else n_pass++;
      n_total++;
      if ({bus4.o_idle, bus4.o_running, bus4.o_done} !== 3'b100) $display("FAIL reset_flags_w4: got %b expected 100", {bus4.o_idle, bus4.o_running, bus4.o_done});
      else n_pass++;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt} !== {3'b100, 7'd0}) $display("FAIL reset_stay_idle: got %b expected 100_0000000", {bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt});
         else n_pass++;
      end
   endtask

   task automatic test_run5();
      bus7.i_run = 1'b1;
      bus7.i_num_cnt = 7'd5;
      @(negedge clk);
      bus7.i_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b010) $display("FAIL run5_flags: got %b expected 010 at cycle %0d", {bus7.o_idle, bus7.o_running, bus7.o_done}, i);
         else n_pass++;
         n_total++;
         if (bus7.o_cnt !== 7'(i)) $display("FAIL run5_cnt: got %0d expected %0d", bus7.o_cnt, i);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt} !== {3'b001, 7'd0}) $display("FAIL run5_done: got %b expected 001_0000000", {bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL run5_idle: got %b expected 100", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
   endtask

   task automatic test_zero();
      bus7.i_run = 1'b1;
      bus7.i_num_cnt = 7'd0;
      @(negedge clk);
      bus7.i_run = 1'b0;
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b001) $display("FAIL zero_done: got %b expected 001", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL zero_idle: got %b expected 100", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_flags [5];
      exp_flags[0] = 3'b010;
      exp_flags[1] = 3'b010;
      exp_flags[2] = 3'b010;
      exp_flags[3] = 3'b001;
      exp_flags[4] = 3'b100;
      bus7.i_run = 1'b1;
      bus7.i_num_cnt = 7'd3;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_total++;
            if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== exp_flags[j]) $display("FAIL b2b_flags: got %b expected %b (period %0d slot %0d)", {bus7.o_idle, bus7.o_running, bus7.o_done}, exp_flags[j], p, j);
            else n_pass++;
            n_total++;
            if (bus7.o_cnt !== ((j < 3) ? 7'(j) : 7'd0)) $display("FAIL b2b_cnt: got %0d expected %0d", bus7.o_cnt, (j < 3) ? j : 0);
            else n_pass++;
         end
      end
      bus7.i_run = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL b2b_stop: got %b expected 100", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
   endtask

   task automatic test_ignore_in_run();
      bus7.i_run = 1'b1;
      bus7.i_num_cnt = 7'd5;
      @(negedge clk);
      bus7.i_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if ({bus7.o_running, bus7.o_cnt} !== {1'b1, 7'(i)}) $display("FAIL ignore_run: got running=%b cnt=%0d expected running=1 cnt=%0d", bus7.o_running, bus7.o_cnt, i);
         else n_pass++;
         if (i == 1) begin
            bus7.i_run = 1'b1;
            bus7.i_num_cnt = 7'd9;
         end else if (i == 2) begin
            bus7.i_run = 1'b0;
         end
         @(negedge clk);
      end
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b001) $display("FAIL ignore_done: got %b expected 001", {bus7.o_idle, bus7.o_running, bus7.o_done});
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL ignore_idle: got %b expected 100", {bus7.o_idle, bus7.o_running, bus7.o_done});
         else n_pass++;
      end
   endtask

   task automatic test_abort();
      bus7.i_run = 1'b1;
      bus7.i_num_cnt = 7'd5;
      @(negedge clk);
      bus7.i_run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if ({bus7.o_running, bus7.o_cnt} !== {1'b1, 7'd2}) $display("FAIL abort_pre: got running=%b cnt=%0d expected running=1 cnt=2", bus7.o_running, bus7.o_cnt);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt} !== {3'b100, 7'd0}) $display("FAIL abort_async: got %b expected 100_0000000", {bus7.o_idle, bus7.o_running, bus7.o_done, bus7.o_cnt});
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_total++;
         if ({bus7.o_idle, bus7.o_running, bus7.o_done} !== 3'b100) $display("FAIL abort_no_done: got %b expected 100 at cycle %0d", {bus7.o_idle, bus7.o_running, bus7.o_done}, i);
         else n_pass++;
      end
   endtask

   task automatic test_wide_max();
      bus4.i_run = 1'b1;
      bus4.i_num_cnt = 4'd15;
      @(negedge clk);
      bus4.i_run = 1'b0;
      for (int i = 0; i < 15; i++) begin
         n_total++;
         if ({bus4.o_idle, bus4.o_running, bus4.o_done, bus4.o_cnt} !== {3'b010, 4'(i)}) $display("FAIL w4_run: got flags=%b cnt=%0d expected flags=010 cnt=%0d", {bus4.o_idle, bus4.o_running, bus4.o_done}, bus4.o_cnt, i);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if ({bus4.o_idle, bus4.o_running, bus4.o_done, bus4.o_cnt} !== {3'b001, 4'd0}) $display("FAIL w4_done: got %b expected 001_0000", {bus4.o_idle, bus4.o_running, bus4.o_done, bus4.o_cnt});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus4.o_idle, bus4.o_running, bus4.o_done} !== 3'b100) $display("FAIL w4_idle: got %b expected 100", {bus4.o_idle, bus4.o_running, bus4.o_done});
      else n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_run5();
      test_zero();
      test_back_to_back();
      test_ignore_in_run();
      test_abort();
      test_wide_max();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
